// File: rtl/uart_pwm_pkg.sv
// Shared encodings and constants for the UART-controlled multi-channel PWM block.
package uart_pwm_pkg;

    // Receiver states
    localparam logic [1:0] RX_IDLE  = 2'd0;
    localparam logic [1:0] RX_START = 2'd1;
    localparam logic [1:0] RX_DATA  = 2'd2;
    localparam logic [1:0] RX_STOP  = 2'd3;

    // Frame parser states
    localparam logic P_ADDR = 1'b0;
    localparam logic P_DATA = 1'b1;

    localparam logic [7:0]  BROADCAST_ADDR = 8'hFF;
    localparam int unsigned TIMEOUT_BITS   = 20;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: two-flop synchroniser, mid-bit sampling, framing-error detection.
module uart_rx_byte
    import uart_pwm_pkg::*;
#(
    parameter int unsigned BIT_CNT = 104
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       RX,
    output logic [7:0] data,
    output logic       byte_valid,
    output logic       frame_err
);

    localparam int unsigned CW = $clog2(BIT_CNT + 1);
    localparam logic [CW-1:0] HALF_M1 = CW'(BIT_CNT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(BIT_CNT - 1);

    logic          rx_meta, rx_sync, rx_prev;
    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;

    // Synchronise RX and keep one delayed copy for falling-edge detection
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= RX;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    // Receive state machine; byte_valid/frame_err are single-cycle strobes
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state      <= RX_IDLE;
            cnt        <= '0;
            bit_idx    <= 3'd0;
            shreg      <= 8'd0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            case (state)
                RX_IDLE: begin
                    cnt     <= '0;
                    bit_idx <= 3'd0;
                    // Edge, not level: a line held low after a bad stop bit must not restart
                    if (rx_prev && !rx_sync) state <= RX_START;
                end
                RX_START: begin
                    if (cnt == HALF_M1) begin
                        cnt   <= '0;
                        state <= rx_sync ? RX_IDLE : RX_DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (cnt == FULL_M1) begin
                        cnt     <= '0;
                        shreg   <= {rx_sync, shreg[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) state <= RX_STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    if (cnt == FULL_M1) begin
                        cnt   <= '0;
                        state <= RX_IDLE;
                        if (rx_sync) byte_valid <= 1'b1;
                        else         frame_err  <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    assign data = shreg;

endmodule

// File: rtl/uart_pwm_multi.sv
// UART-controlled multi-channel PWM: two-byte frames (address, duty) set per-channel duty.
// Optional build macro UART_PWM_FADE_EN: active duty ramps by 1 per period toward target.
module uart_pwm_multi
    import uart_pwm_pkg::*;
#(
    parameter int unsigned CLK_FREQ  = 12_000_000,
    parameter int unsigned BAUD_RATE = 115200,
    parameter int unsigned PWM_FREQ  = 1000,
    parameter int unsigned NUM_CH    = 4
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              RX,
    output logic [NUM_CH-1:0] LED,
    output logic              ERR
);

    localparam int unsigned BIT_CNT    = CLK_FREQ / BAUD_RATE;
    localparam int unsigned PWM_PERIOD = CLK_FREQ / PWM_FREQ;
    localparam int unsigned TMO_CYCLES = TIMEOUT_BITS * BIT_CNT;
    localparam int unsigned PW = $clog2(PWM_PERIOD + 1);
    localparam int unsigned AW = $clog2(PWM_PERIOD + 256);
    localparam int unsigned TW = $clog2(TMO_CYCLES + 1);

    logic [7:0]  rx_data;
    logic        rx_valid, rx_ferr;

    logic        pstate;
    logic [7:0]  addr_q;
    logic [TW-1:0] tmo_q;
    logic [7:0]  target_q [NUM_CH];
    logic [7:0]  active_q [NUM_CH];

    logic [PW-1:0] pcnt_q;
    logic [AW-1:0] acc_q, acc_sum;
    logic [7:0]    slot_q;
    logic          wrap;
    logic [NUM_CH-1:0] led_d;

    uart_rx_byte #(
        .BIT_CNT (BIT_CNT)
    ) u_rx (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .RX         (RX),
        .data       (rx_data),
        .byte_valid (rx_valid),
        .frame_err  (rx_ferr)
    );

    // Frame parser: address byte then value byte, with a timeout that drops a stale address
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            pstate <= P_ADDR;
            addr_q <= 8'd0;
            tmo_q  <= '0;
            ERR    <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) target_q[i] <= 8'd0;
        end else begin
            ERR <= rx_ferr;
            case (pstate)
                P_ADDR: begin
                    tmo_q <= '0;
                    if (rx_valid) begin
                        addr_q <= rx_data;
                        pstate <= P_DATA;
                    end
                end
                default: begin
                    if (rx_valid) begin
                        pstate <= P_ADDR;
                        if (addr_q == BROADCAST_ADDR) begin
                            for (int i = 0; i < NUM_CH; i++) target_q[i] <= rx_data;
                        end else if (addr_q < 8'(NUM_CH)) begin
                            for (int i = 0; i < NUM_CH; i++)
                                if (addr_q == 8'(i)) target_q[i] <= rx_data;
                        end else begin
                            ERR <= 1'b1;
                        end
                    end else if (tmo_q == TW'(TMO_CYCLES - 1)) begin
                        pstate <= P_ADDR;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
            endcase
        end
    end

    assign wrap = (pcnt_q == PW'(PWM_PERIOD - 1));

    // acc_q tracks (pcnt*256) mod PWM_PERIOD so slot_q == floor(pcnt*256/PWM_PERIOD)
    always_comb acc_sum = acc_q + AW'(256);

    // Shared period counter and 0..255 slot index
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            pcnt_q <= '0;
            acc_q  <= '0;
            slot_q <= 8'd0;
        end else if (wrap) begin
            pcnt_q <= '0;
            acc_q  <= '0;
            slot_q <= 8'd0;
        end else begin
            pcnt_q <= pcnt_q + 1'b1;
            if (acc_sum >= AW'(PWM_PERIOD)) begin
                acc_q  <= acc_sum - AW'(PWM_PERIOD);
                slot_q <= slot_q + 8'd1;
            end else begin
                acc_q <= acc_sum;
            end
        end
    end

    // Active duty only changes on the wrap cycle so no period is cut short
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < NUM_CH; i++) active_q[i] <= 8'd0;
        end else if (wrap) begin
            for (int i = 0; i < NUM_CH; i++) begin
`ifdef UART_PWM_FADE_EN
                if (active_q[i] < target_q[i])      active_q[i] <= active_q[i] + 8'd1;
                else if (active_q[i] > target_q[i]) active_q[i] <= active_q[i] - 8'd1;
`else
                active_q[i] <= target_q[i];
`endif
            end
        end
    end

    // Duty 255 is forced fully on; the slot compare alone would drop the last slot
    always_comb begin
        led_d = '0;
        for (int i = 0; i < NUM_CH; i++)
            led_d[i] = (active_q[i] == 8'hFF) || (slot_q < active_q[i]);
    end

    // Registered LED outputs
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) LED <= '0;
        else        LED <= led_d;
    end

endmodule

// File: tb/tb_uart_pwm_multi.sv
// Directed bench for uart_pwm_multi: a duty model feeds a scoreboard queue, and each popped
// entry is compared with per-channel LED high-time measured over one PWM period.
module tb_uart_pwm_multi;

    localparam int unsigned CLK_FREQ = 1_000_000;
    localparam int unsigned BAUD     = 100_000;
    localparam int unsigned PWMF     = 1000;
    localparam int unsigned NCH      = 4;
    localparam int BC = CLK_FREQ / BAUD;
    localparam int P  = CLK_FREQ / PWMF;

    logic           CLK = 1'b0;
    logic           RST_N = 1'b0;
    logic           RX = 1'b1;
    logic [NCH-1:0] LED;
    logic           ERR;

    int checks = 0;
    int errors = 0;
    int err_cycles = 0;
    int exp_err = 0;
    logic [7:0]  mdl [NCH];
    logic [31:0] exp_q [$];

    uart_pwm_multi #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD_RATE (BAUD),
        .PWM_FREQ  (PWMF),
        .NUM_CH    (NCH)
    ) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .RX    (RX),
        .LED   (LED),
        .ERR   (ERR)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) if (ERR === 1'b1) err_cycles++;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        RX = 1'b0;
        tick(BC);
        for (int i = 0; i < 8; i++) begin
            RX = b[i];
            tick(BC);
        end
        RX = stop;
        tick(BC);
        RX = 1'b1;
        tick(BC);
    endtask

    // Reference high time for one period: slot = floor(cycle*256/P), duty 255 is full on
    function automatic int hi_count(input logic [7:0] d);
        int n = 0;
        if (d == 8'hFF) return P;
        for (int c = 0; c < P; c++) if ((c * 256) / P < int'(d)) n++;
        return n;
    endfunction

    task automatic push_model();
        exp_q.push_back({mdl[3], mdl[2], mdl[1], mdl[0]});
    endtask

    task automatic frame(input logic [7:0] a, input logic [7:0] v);
        send_byte(a, 1'b1);
        send_byte(v, 1'b1);
        if (a == 8'hFF) begin
            for (int i = 0; i < NCH; i++) mdl[i] = v;
        end else if (a < 8'(NCH)) begin
            mdl[a[1:0]] = v;
        end else begin
            exp_err++;
        end
        push_model();
    endtask

    // Let the next wrap load the duty, then count LED high cycles over one full period
    task automatic check_leds(input string tag);
        logic [31:0] e;
        int hi [NCH];
        e = exp_q.pop_front();
        tick(2 * P);
        for (int i = 0; i < NCH; i++) hi[i] = 0;
        repeat (P) begin
            @(negedge CLK);
            for (int i = 0; i < NCH; i++) if (LED[i] === 1'b1) hi[i]++;
        end
        for (int i = 0; i < NCH; i++)
            check($sformatf("%s_led%0d", tag, i), hi[i], hi_count(e[8*i +: 8]));
    endtask

    initial begin
        for (int i = 0; i < NCH; i++) mdl[i] = 8'd0;
        tick(3);
        check("rst_led", int'(LED), 0);
        check("rst_err", int'(ERR), 0);
        RST_N = 1'b1;
        tick(BC);

`ifdef UART_PWM_FADE_EN
        frame(8'h00, 8'h04);
        void'(exp_q.pop_front());
        for (int k = 1; k <= 6; k++) begin
            int guard = 0;
            @(negedge CLK);
            while (dut.pcnt_q != 0 && guard < 2 * P) begin
                @(negedge CLK);
                guard++;
            end
            check($sformatf("fade_wrap%0d", k), int'(dut.active_q[0]), (k < 4) ? k : 4);
        end
`else
        // Single channel at half duty
        frame(8'h01, 8'h80);
        check_leds("ch1_half");

        // Broadcast full on, then broadcast off
        frame(8'hFF, 8'hFF);
        check_leds("bcast_on");
        frame(8'hFF, 8'h00);
        check_leds("bcast_off");

        // Out-of-range address: one ERR pulse, nothing written
        frame(8'h01, 8'h30);
        check_leds("pre_bad");
        frame(8'h07, 8'h40);
        check_leds("bad_addr");
        check("bad_addr_err", err_cycles, exp_err);

        // Stale address times out; next bytes form a fresh frame
        send_byte(8'h02, 1'b1);
        tick(25 * BC);
        frame(8'h03, 8'h20);
        check_leds("timeout");
        check("timeout_err", err_cycles, exp_err);

        // Framing error: ERR pulse and no parser advance
        send_byte(8'h55, 1'b0);
        tick(BC);
        exp_err++;
        frame(8'h00, 8'h10);
        check_leds("frame_err");
        check("frame_err_cnt", err_cycles, exp_err);

        // Reset in the middle of a byte discards it and clears all duties
        RX = 1'b0;
        tick(BC);
        RX = 1'b1;
        tick(3 * BC);
        RST_N = 1'b0;
        tick(2);
        check("mid_rst_led", int'(LED), 0);
        check("mid_rst_err", int'(ERR), 0);
        RST_N = 1'b1;
        for (int i = 0; i < NCH; i++) mdl[i] = 8'd0;
        tick(BC);
        frame(8'h02, 8'hC0);
        check_leds("after_rst");
        check("final_err", err_cycles, exp_err);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
